// File: rtl/inst_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
// Optional same-cycle bypass is enabled by defining INST_QUEUE_BYPASS_EN.
package inst_queue_pkg;

    localparam int          IQ_DEFAULT_DEPTH = 4;
    localparam logic [31:0] IQ_NOP           = 32'h0000_0000;

    // 65-bit storage word: {pc, instr, adel}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch push / decode pop bundle for inst_queue; the queue takes the slave modport.
interface inst_queue_if #(
    parameter int CNT_W = 3
);
    logic             push_valid;
    logic [31:0]      push_pc;
    logic [31:0]      push_instr;
    logic             push_adel;
    logic             push_ready;
    logic             pop_ready;
    logic             validD;
    logic [31:0]      instrD;
    logic [31:0]      pcD;
    logic             adelD;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output push_valid, push_pc, push_instr, push_adel, pop_ready,
        input  push_ready, validD, instrD, pcD, adelD, count, full, empty
    );

    modport slave (
        input  push_valid, push_pc, push_instr, push_adel, pop_ready,
        output push_ready, validD, instrD, pcD, adelD, count, full, empty
    );
endinterface

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
module inst_queue_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  iq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output iq_entry_t        rdata
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush; head entry presented combinationally.
// Define INST_QUEUE_BYPASS_EN to forward a push straight to decode when the queue is empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    inst_queue_if.slave q
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             byp_hit;
    logic             byp_consume;
    logic             do_push;
    logic             do_pop;
    logic             out_valid;
    iq_entry_t        wr_entry;
    iq_entry_t        head;
    iq_entry_t        out_entry;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_entry = '{pc: q.push_pc, instr: q.push_instr, adel: q.push_adel};

`ifdef INST_QUEUE_BYPASS_EN
    assign byp_hit = empty & q.push_valid & ~flush;
`else
    assign byp_hit = 1'b0;
`endif

    // A bypassed entry consumed by decode in the same cycle is never stored.
    assign byp_consume = byp_hit & q.pop_ready;
    assign do_push     = q.push_valid & ~full & ~flush & ~byp_consume;
    assign do_pop      = q.pop_ready & ~empty & ~flush;

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_valid = ~empty | byp_hit;
        out_entry = byp_hit ? wr_entry : head;
        if (!out_valid) begin
            out_entry = '{pc: 32'h0, instr: IQ_NOP, adel: 1'b0};
        end
    end

    assign q.push_ready = ~full;
    assign q.validD     = out_valid;
    assign q.instrD     = out_entry.instr;
    assign q.pcD        = out_entry.pc;
    assign q.adelD      = out_entry.adel;
    assign q.count      = count;
    assign q.full       = full;
    assign q.empty      = empty;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue tracks accepted entries and
// every cycle the DUT head/status outputs are compared against it.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    inst_queue_if #(.CNT_W(CNT_W)) qi ();

    inst_queue #(.DEPTH(DEPTH), .PTR_W(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (qi)
    );

    always #5 clk = ~clk;

    // Reference entries packed as {pc, instr, adel}
    logic [64:0] sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        flush         = 1'b0;
        qi.push_valid = 1'b0;
        qi.pop_ready  = 1'b0;
        qi.push_pc    = '0;
        qi.push_instr = '0;
        qi.push_adel  = 1'b0;
        @(posedge clk);
        sb.delete();
    endtask

    // One clock: drive inputs, compare outputs before the edge, then advance the model.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic adel, input logic pr, input logic fl);
        logic        exp_valid;
        logic [64:0] exp_head;
        logic        byp;
        logic        acc;
        logic        pop;
        @(negedge clk);
        rst           = 1'b0;
        flush         = fl;
        qi.push_valid = pv;
        qi.push_pc    = pc;
        qi.push_instr = ins;
        qi.push_adel  = adel;
        qi.pop_ready  = pr;
        #1;
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && pv && !fl;
`endif
        exp_valid = (sb.size() != 0) || byp;
        if (byp)                  exp_head = {pc, ins, adel};
        else if (sb.size() != 0)  exp_head = sb[0];
        else                      exp_head = '0;
        check("validD",     {31'b0, qi.validD},     {31'b0, exp_valid});
        check("pcD",        qi.pcD,                 exp_head[64:33]);
        check("instrD",     qi.instrD,              exp_head[32:1]);
        check("adelD",      {31'b0, qi.adelD},      {31'b0, exp_head[0]});
        check("count",      {29'b0, qi.count},      sb.size());
        check("full",       {31'b0, qi.full},       {31'b0, sb.size() == DEPTH});
        check("empty",      {31'b0, qi.empty},      {31'b0, sb.size() == 0});
        check("push_ready", {31'b0, qi.push_ready}, {31'b0, sb.size() != DEPTH});
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            acc = pv && (sb.size() < DEPTH) && !(byp && pr);
            pop = pr && (sb.size() != 0);
            if (pop) void'(sb.pop_front());
            if (acc) sb.push_back({pc, ins, adel});
        end
    endtask

    task automatic idle(input logic pr);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, pr, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic pr);
        cyc(1'b1, pc, ins, 1'b0, pr, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        do_reset();
        do_reset();
        idle(1'b0);

        // Two pushes, stalled decode, then drain
        push(32'hBFC0_0000, 32'h2408_0001, 1'b0);
        push(32'hBFC0_0004, 32'h0000_0000, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill, hold a fifth push while full, then let it in after one pop
        for (int i = 0; i < 4; i++) push(32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
        push(32'hBFC0_0010, 32'h1000_0004, 1'b0);
        push(32'hBFC0_0010, 32'h1000_0004, 1'b1);
        push(32'hBFC0_0010, 32'h1000_0004, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap-around streaming at occupancy 2
        pc = 32'hBFC0_0100;
        for (int i = 0; i < 12; i++) begin
            push(pc, 32'h2000_0000 + 32'(i), i >= 2);
            pc += 4;
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with three entries plus a concurrent push
        for (int i = 0; i < 3; i++) push(32'hBFC0_0200 + 32'(4 * i), 32'h3000_0000 + 32'(i), 1'b0);
        cyc(1'b1, 32'hBFC0_020C, 32'h3000_0003, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Address-error flag propagates to the head
        cyc(1'b1, 32'hBFC0_0001, 32'h2408_0002, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Push into empty queue with decode ready (bypass only when enabled)
        push(32'hBFC0_0300, 32'h2408_0003, 1'b1);
        idle(1'b1);

        // Mid-operation reset
        push(32'hBFC0_0400, 32'h4000_0000, 1'b0);
        push(32'hBFC0_0404, 32'h4000_0001, 1'b0);
        do_reset();
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 5; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
